// File: rtl/iq_upconverter.sv
// IQ upconverter: 2-deep baseband FIFO, linear interpolator and NCO mixer.
// Drives an offset-binary DAC word from I*cos - Q*sin.
module iq_upconverter #(
  parameter int N           = 14,
  parameter int INTERP_LOG2 = 4
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_i,
  input  logic signed [N-1:0] in_q,
  input  logic signed [N-1:0] nco_cos,
  input  logic signed [N-1:0] nco_sin,
  input  logic                nco_valid,
  output logic        [N-1:0] dac_out,
  output logic                out_valid,
  output logic                underrun,
  input  logic                underrun_clr
);

  localparam int L  = INTERP_LOG2;
  localparam int AW = N + L + 1;
  localparam int DW = N + 1;
  localparam int PW = 2 * N;
  localparam int SW = 2 * N + 1;

  localparam logic [N-1:0] MID = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** (N - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  localparam logic signed [SW-1:0] RND  = SW'(2 ** (N - 2));

  typedef struct packed {
    logic signed [N-1:0] i;
    logic signed [N-1:0] q;
  } iq_t;

  iq_t        mem [2];
  iq_t        head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign in_ready = !reset && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_i, in_q};
        wr_ptr      <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  logic [L-1:0] cnt;
  logic         wrap;
  logic         starve;

  assign wrap   = enable && (cnt == {L{1'b1}});
  assign pop    = wrap && !empty;
  assign starve = wrap && empty;

  // A same-cycle starvation wins over the clear request.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      underrun <= 1'b0;
    end else begin
      if (enable) begin
        cnt <= cnt + 1'b1;
      end
      if (starve) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  logic signed [N-1:0] nxt    [2];
  logic signed [N-1:0] interp [2];

  assign nxt[0] = head.i;
  assign nxt[1] = head.q;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic signed [N-1:0]  tgt;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] dlt;

    // acc holds value << L so a segment lands exactly on its target.
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        tgt <= '0;
        acc <= '0;
        dlt <= '0;
      end else begin
        unique case (1'b1)
          pop: begin
            tgt <= nxt[c];
            acc <= {tgt[N-1], tgt, {L{1'b0}}};
            dlt <= {nxt[c][N-1], nxt[c]} - {tgt[N-1], tgt};
          end
          starve: begin
            acc <= {tgt[N-1], tgt, {L{1'b0}}};
            dlt <= '0;
          end
          (enable && !wrap): begin
            acc <= acc + {{L{dlt[DW-1]}}, dlt};
          end
          default: ;
        endcase
      end
    end

    assign interp[c] = acc[L +: N];
  end

  logic signed [N-1:0]  s1_i;
  logic signed [N-1:0]  s1_q;
  logic signed [N-1:0]  s1_c;
  logic signed [N-1:0]  s1_s;
  logic                 s1_g;
  logic signed [PW-1:0] p_i;
  logic signed [PW-1:0] p_q;
  logic                 s2_g;
  logic signed [SW-1:0] diff;
  logic signed [SW-1:0] sh;
  logic        [N-1:0]  clip;

  assign diff = SW'(p_i) - SW'(p_q);
  assign sh   = (diff + RND) >>> (N - 1);

  always_comb begin
    clip = sh[N-1:0];
    unique case (1'b1)
      (sh > MAXV): clip = MAXV[N-1:0];
      (sh < MINV): clip = MINV[N-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s1_i      <= '0;
      s1_q      <= '0;
      s1_c      <= '0;
      s1_s      <= '0;
      s1_g      <= 1'b0;
      p_i       <= '0;
      p_q       <= '0;
      s2_g      <= 1'b0;
      dac_out   <= MID;
      out_valid <= 1'b0;
    end else begin
      s1_i      <= interp[0];
      s1_q      <= interp[1];
      s1_c      <= nco_cos;
      s1_s      <= nco_sin;
      s1_g      <= enable && nco_valid;
      p_i       <= PW'(s1_i) * PW'(s1_c);
      p_q       <= PW'(s1_q) * PW'(s1_s);
      s2_g      <= s1_g;
      dac_out   <= s2_g ? (clip ^ MID) : MID;
      out_valid <= s2_g;
    end
  end

endmodule
